conv_window_buffer: RTL and testbench
=====================================

# conv_window_buffer

Builds the convolution window that the IPU sequencer feeds to the convolution coprocessor as operand A. It sits between the frame memory read port and the coprocessor. It captures whole image rows streamed from memory as 32-bit words of four pixels each, keeps the last K rows in a ring of line buffers, and presents a zero-padded K×K pixel window. The window steps one column each time the sequencer accepts a convolution result.

## Interface
- IMG_W, 512: pixels per row (128 memory words).
- IMG_H, 480: rows per frame.
- PIX_W, 8: bits per pixel.
- WIN_MAX, 5: largest window edge; sets the number of line buffers.
- clk  in  1: system clock; all logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- word_in  in  32: memory read data; pixel 4n+0 in [7:0] through pixel 4n+3 in [31:24].
- load_valid  in  1: a row-load read is being issued this cycle at address {v_count, h_count[8:2]}.
- h_count  in  9: pixel column of the issued read; always a multiple of 4.
- v_count  in  9: image row of the issued read.
- size  in  2: kernel size code. 00 = 2×2 (Roberts), 01 = 3×3, 10 = 5×5, 11 = 5×5.
- next_matrix  in  1: one-cycle pulse that advances the window by one column.
- window_out  out  200: 5×5 window, row-major; element (r,c) is at [8*(5r+c)+:8]. Entries outside K×K are 0.
- window_valid  out  1: window_out matches the current column.
- rows_ready  out  1: at least K rows have been captured since the last frame start.

## Operation
- Memory read latency is one cycle. load_valid, h_count and v_count are delayed one cycle, and word_in is written into line buffer wr_slot, word h_count_d[8:2].
- When a written word has h_count_d = 508 (end of row), wr_slot advances modulo 5 and rows_cnt increments, saturating at 5.
- A load with v_count_d = 0 and h_count_d = 0 starts a new frame: wr_slot = 0, rows_cnt = 0, wcol = 0, rows_ready = 0.
- K is derived from size: {2, 3, 5, 5}. The anchor offset A is {0, 1, 2, 2}.
- Window rows: r = 0 is the oldest of the last K completed rows, through r = K-1 the newest.
- Window columns: column c reads pixel wcol - A + c. Column indices below 0 or above IMG_W-1 read as 0.
- next_matrix increments wcol. When wcol = IMG_W-1, it instead wraps wcol to 0.
- Any end-of-row write also resets wcol to 0, because the sequencer reloads before each new output row.
- States:
  - IDLE: rows_cnt < K.
  - FILL: a row is being written.
  - READY: rows_cnt ≥ K and no write is pending.
  - Transitions: IDLE/READY → FILL on load_valid_d. FILL → READY when the end-of-row write leaves rows_cnt ≥ K; otherwise FILL → IDLE.
- rows_ready = (rows_cnt ≥ K).
- window_valid = READY and no wcol change is pending.
- If load_valid_d and next_matrix arrive in the same cycle, both take effect. The write to the line buffer and the wcol increment happen together. The gather uses the post-write buffer contents.
- A size change while READY takes effect on the next gather, and window_valid drops for one cycle.

## Timing
- Reset values: window_out = 0, window_valid = 0, rows_ready = 0, wr_slot = 0, rows_cnt = 0, wcol = 0, state = IDLE. Line buffer contents are not cleared.
- Write latency: a word issued at cycle t is stored at the t+1 edge.
- Gather latency: window_out is registered. It reflects a wcol or slot change one cycle later, and window_valid rises in that same cycle.
- Cycle timeline:
  - next_matrix at cycle t: window_valid = 0 at t+1; new window and window_valid = 1 at t+2.
  - End-of-row write at cycle t, completing rows_cnt ≥ K: rows_ready = 1 at t+1; window_valid = 1 at t+2.
- Reset asserted mid-row: all pointers clear on that edge. Partial row data is kept but is unreachable until it is rewritten.

## Structure
- Shared package (ipu_pkg) holds:
  - size codes and the K/A lookup;
  - IMG_W, IMG_H, PIX_W, WIN_MAX;
  - state encodings IDLE, FILL, READY.
- One sub-module, cwb_line_ram: 128×32 storage with a single write port and a byte-addressed read of 5 consecutive pixels. It is instantiated 5 times.
- Top level holds the delay registers, slot/row counters, state machine, wcol, and the registered gather/zero-pad mux.

## Test plan
- Reset during FILL at h = 200 → all outputs 0 next cycle. A fresh 3-row load with size = 01 then gives rows_ready = 1.
- size = 01; load rows 0–2 with pixel value = (row·16 + col) mod 256; wcol = 0 → window row 0 = {0, 0x00, 0x01}, row 2 = {0, 0x20, 0x21}, all other bytes 0.
- size = 10; load 5 rows; pulse next_matrix 511 times → window column 4 reads 0, column 2 reads pixel 511; window_valid is low for exactly 1 cycle after each pulse.
- size = 00; 2 rows loaded → rows_ready = 1 after the 2nd row's 508 write. A 3rd row load evicts row 0, so window row 0 = row 1 data.
- load_valid_d and next_matrix in the same cycle → the word is stored, wcol advances by 1, and the window is valid 2 cycles later.
- Frame restart (v = 0, h = 0 load) after a full frame → rows_ready drops the next cycle; wr_slot = 0 and wcol = 0.

Source files
------------

// File: rtl/ipu_pkg.sv
// ipu_pkg: image geometry, kernel size codes, K/anchor lookup and window-buffer state encodings.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package ipu_pkg;

   localparam int IMG_W    = 512;
   localparam int IMG_H    = 480;
   localparam int PIX_W    = 8;
   localparam int WIN_MAX  = 5;
   localparam int LB_WORDS = IMG_W / 4;

   // Last pixel column, and the column of the final word of a row.
   localparam logic [8:0] COL_LAST  = 9'(IMG_W - 1);
   localparam logic [8:0] ROW_END_H = 9'(IMG_W - 4);
   localparam logic [2:0] NUM_LB    = 3'(WIN_MAX);

   localparam logic [1:0] SIZE_2X2     = 2'b00;
   localparam logic [1:0] SIZE_3X3     = 2'b01;
   localparam logic [1:0] SIZE_5X5     = 2'b10;
   localparam logic [1:0] SIZE_5X5_ALT = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      READY = 2'd2
   } state_t;

   // Window edge K for a size code.
   function automatic logic [2:0] win_k(input logic [1:0] sz);
      case (sz)
         SIZE_2X2: return 3'd2;
         SIZE_3X3: return 3'd3;
         default:  return 3'd5;
      endcase
   endfunction

   // Anchor offset A: how many columns the window extends left of wcol.
   function automatic logic [1:0] win_a(input logic [1:0] sz);
      case (sz)
         SIZE_2X2: return 2'd0;
         SIZE_3X3: return 2'd1;
         default:  return 2'd2;
      endcase
   endfunction

   // Next ring slot after ws.
   function automatic logic [2:0] slot_inc(input logic [2:0] ws);
      return (ws == NUM_LB - 3'd1) ? 3'd0 : ws + 3'd1;
   endfunction

   // Ring slot holding window row r: (ws - k + r) mod 5, r = 0 oldest.
   function automatic logic [2:0] row_slot(input logic [2:0] ws, input logic [2:0] k,
                                           input logic [2:0] r);
      logic [3:0] t;
      t = {1'b0, ws} + {1'b0, NUM_LB} - {1'b0, k} + {1'b0, r};
      if (t >= 4'd10)
         t = t - 4'd10;
      else if (t >= 4'd5)
         t = t - 4'd5;
      return t[2:0];
   endfunction

endpackage

// File: rtl/cwb_line_ram.sv
// cwb_line_ram: one image row of 128 x 32-bit words, one write port, 5-pixel byte-addressed read.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none; a write is accepted every cycle we is high.
module cwb_line_ram
   import ipu_pkg::*;
(
   input  logic        clk,
   input  logic        we,
   input  logic [6:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [8:0]  rd_addr,
   output logic [39:0] rd_pix
);

   logic [31:0] mem [LB_WORDS];
   logic [8:0]  pa  [WIN_MAX];

   // Store one 4-pixel word of the row.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Pixel addresses wrap modulo the row; the caller masks out-of-row columns.
   genvar c;
   generate
      for (c = 0; c < WIN_MAX; c++) begin : g_pix
         assign pa[c] = rd_addr + 9'(c);
         assign rd_pix[PIX_W*c +: PIX_W] = mem[pa[c][8:2]][{pa[c][1:0], 3'b000} +: PIX_W];
      end
   endgenerate

endmodule

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: captures streamed rows into a 5-slot line-buffer ring, presents a zero-padded KxK window.
// Latency: word stored one cycle after its read is issued; window_out registered, valid 2 cycles after a column step.
// Backpressure: none; every load is accepted, window_valid stays low while a column/slot/size change settles.
module conv_window_buffer
   import ipu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  word_in,
   input  logic         load_valid,
   input  logic [8:0]   h_count,
   input  logic [8:0]   v_count,
   input  logic [1:0]   size,
   input  logic         next_matrix,
   output logic [199:0] window_out,
   output logic         window_valid,
   output logic         rows_ready
);

   logic         load_valid_d;
   logic [8:0]   h_count_d;
   logic [8:0]   v_count_d;
   logic [2:0]   wr_slot, wr_slot_nx;
   logic [2:0]   rows_cnt, rows_cnt_nx;
   logic [8:0]   wcol, wcol_nx;
   state_t       state, state_nx;
   logic [1:0]   size_q;
   logic         pend;
   logic         eor_wr, frame_wr, change_now;
   logic [2:0]   k, wr_sel;
   logic [1:0]   a;
   logic [10:0]  start;
   logic [10:0]  p;
   logic [39:0]  rd_pix [WIN_MAX];
   logic [199:0] window_nx;

   assign k          = win_k(size);
   assign a          = win_a(size);
   assign eor_wr     = load_valid_d && (h_count_d == ROW_END_H);
   assign frame_wr   = load_valid_d && (h_count_d == 9'd0) && (v_count_d == 9'd0);
   // A frame-start word belongs in slot 0 even though wr_slot only clears on this edge.
   assign wr_sel     = frame_wr ? 3'd0 : wr_slot;
   // Leftmost window column; signed, may be up to two pixels left of the row.
   assign start      = {2'b00, wcol} - {9'd0, a};
   assign change_now = next_matrix || eor_wr || frame_wr || (size != size_q);
   assign rows_ready   = (rows_cnt >= k);
   assign window_valid = (state == READY) && !pend;

   genvar s;
   generate
      for (s = 0; s < WIN_MAX; s++) begin : g_lb
         cwb_line_ram u_ram (
            .clk     (clk),
            .we      (load_valid_d && (wr_sel == 3'(s))),
            .waddr   (h_count_d[8:2]),
            .wdata   (word_in),
            .rd_addr (start[8:0]),
            .rd_pix  (rd_pix[s])
         );
      end
   endgenerate

   // Pointer, counter and state updates; frame start outranks end-of-row, both outrank a column step.
   always_comb begin
      wr_slot_nx  = wr_slot;
      rows_cnt_nx = rows_cnt;
      wcol_nx     = wcol;
      state_nx    = state;
      if (next_matrix)
         wcol_nx = (wcol == COL_LAST) ? 9'd0 : wcol + 9'd1;
      if (frame_wr) begin
         wr_slot_nx  = 3'd0;
         rows_cnt_nx = 3'd0;
         wcol_nx     = 9'd0;
      end else if (eor_wr) begin
         wr_slot_nx = slot_inc(wr_slot);
         if (rows_cnt != NUM_LB)
            rows_cnt_nx = rows_cnt + 3'd1;
         wcol_nx = 9'd0;
      end
      case (state)
         FILL: begin
            if (!load_valid_d || eor_wr)
               state_nx = (rows_cnt_nx >= k) ? READY : IDLE;
         end
         default: begin
            if (load_valid_d && !eor_wr)
               state_nx = FILL;
            else
               state_nx = (rows_cnt_nx >= k) ? READY : IDLE;
         end
      endcase
   end

   // Gather the KxK window from the ring (post-write contents) and zero everything outside it.
   always_comb begin
      window_nx = '0;
      p         = '0;
      for (int r = 0; r < WIN_MAX; r++) begin
         for (int c = 0; c < WIN_MAX; c++) begin
            p = start + 11'(c);
            if ((3'(r) < k) && (3'(c) < k) && (p[10:9] == 2'b00))
               window_nx[PIX_W*(WIN_MAX*r + c) +: PIX_W] =
                  rd_pix[row_slot(wr_slot, k, 3'(r))][PIX_W*c +: PIX_W];
         end
      end
   end

   // Register delay stage, pointers, FSM and the gathered window.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_valid_d <= 1'b0;
         h_count_d    <= '0;
         v_count_d    <= '0;
         wr_slot      <= '0;
         rows_cnt     <= '0;
         wcol         <= '0;
         state        <= IDLE;
         size_q       <= size;
         pend         <= 1'b0;
         window_out   <= '0;
      end else begin
         load_valid_d <= load_valid;
         h_count_d    <= h_count;
         v_count_d    <= v_count;
         wr_slot      <= wr_slot_nx;
         rows_cnt     <= rows_cnt_nx;
         wcol         <= wcol_nx;
         state        <= state_nx;
         size_q       <= size;
         pend         <= change_now;
         window_out   <= window_nx;
      end
   end

endmodule

// File: tb/tb_conv_window_buffer.sv
module tb_conv_window_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  word_in;
   logic         load_valid;
   logic [8:0]   h_count;
   logic [8:0]   v_count;
   logic [1:0]   size;
   logic         next_matrix;
   logic [199:0] window_out;
   logic         window_valid;
   logic         rows_ready;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   conv_window_buffer dut (
      .clk          (clk),
      .rst          (rst),
      .word_in      (word_in),
      .load_valid   (load_valid),
      .h_count      (h_count),
      .v_count      (v_count),
      .size         (size),
      .next_matrix  (next_matrix),
      .window_out   (window_out),
      .window_valid (window_valid),
      .rows_ready   (rows_ready)
   );

   function automatic logic [7:0] pix(input int row, input int col);
      return 8'((row * 16 + col) & 255);
   endfunction

   function automatic logic [31:0] row_word(input int row, input int w);
      return {pix(row, 4*w+3), pix(row, 4*w+2), pix(row, 4*w+1), pix(row, 4*w)};
   endfunction

   // Expected window for image rows r0..r0+k-1, anchor a, column wc.
   function automatic logic [199:0] exp_win(input int k, input int a, input int wc, input int r0);
      logic [199:0] w;
      int col;
      w = '0;
      for (int r = 0; r < k; r++) begin
         for (int c = 0; c < k; c++) begin
            col = wc - a + c;
            if (col >= 0 && col < 512)
               w[8*(5*r+c) +: 8] = pix(r0 + r, col);
         end
      end
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue a full row of reads; data follows one cycle later. Returns in the end-of-row write cycle.
   task automatic load_row(input int row, input bit chk_frame);
      for (int w = 0; w <= 128; w++) begin
         step();
         if (chk_frame && w == 2) begin
            chk("frame_rows_ready", {199'd0, rows_ready}, 200'd0);
            chk("frame_valid", {199'd0, window_valid}, 200'd0);
         end
         word_in    = (w > 0) ? row_word(row, w - 1) : 32'h0;
         load_valid = (w < 128);
         h_count    = 9'(4 * w);
         v_count    = 9'(row);
      end
   endtask

   logic [199:0] lit;
   logic [199:0] ex;

   initial begin
      rst = 1'b1; word_in = '0; load_valid = 1'b0; h_count = '0; v_count = '0;
      size = 2'b01; next_matrix = 1'b0;
      lit = '0;
      lit[8*1 +: 8]  = 8'h00; lit[8*2 +: 8]  = 8'h01;
      lit[8*6 +: 8]  = 8'h10; lit[8*7 +: 8]  = 8'h11;
      lit[8*11 +: 8] = 8'h20; lit[8*12 +: 8] = 8'h21;

      step(); step();
      chk("rst_window", window_out, 200'd0);
      chk("rst_valid", {199'd0, window_valid}, 200'd0);
      chk("rst_rows_ready", {199'd0, rows_ready}, 200'd0);
      rst = 1'b0;
      step();

      // 3x3: three rows
      load_row(0, 1'b0); step();
      load_row(1, 1'b0); step();
      chk("k3_rows_ready_after2", {199'd0, rows_ready}, 200'd0);
      load_row(2, 1'b0); step();
      chk("k3_rows_ready", {199'd0, rows_ready}, 200'd1);
      chk("k3_valid_t1", {199'd0, window_valid}, 200'd0);
      step();
      chk("k3_valid_t2", {199'd0, window_valid}, 200'd1);
      chk("k3_window", window_out, lit);

      // Reset in the middle of a row at h = 200
      for (int w = 0; w <= 50; w++) begin
         step();
         word_in    = (w > 0) ? row_word(3, w - 1) : 32'h0;
         load_valid = 1'b1;
         h_count    = 9'(4 * w);
         v_count    = 9'd3;
      end
      rst = 1'b1;
      step();
      chk("midrow_rst_window", window_out, 200'd0);
      chk("midrow_rst_valid", {199'd0, window_valid}, 200'd0);
      chk("midrow_rst_rows_ready", {199'd0, rows_ready}, 200'd0);
      rst = 1'b0; load_valid = 1'b0; h_count = '0; v_count = '0;
      step();

      // Fresh 3-row frame
      load_row(0, 1'b0); step();
      load_row(1, 1'b0); step();
      load_row(2, 1'b0); step();
      chk("fresh_rows_ready", {199'd0, rows_ready}, 200'd1);
      step();
      chk("fresh_window", window_out, lit);

      // 5x5: two more rows
      size = 2'b10;
      load_row(3, 1'b0); step();
      chk("k5_rows_ready_after4", {199'd0, rows_ready}, 200'd0);
      load_row(4, 1'b0); step();
      chk("k5_rows_ready", {199'd0, rows_ready}, 200'd1);
      chk("k5_valid_t1", {199'd0, window_valid}, 200'd0);
      step();
      chk("k5_valid_t2", {199'd0, window_valid}, 200'd1);
      chk("k5_window_w0", window_out, exp_win(5, 2, 0, 0));

      // Step across the whole row
      for (int i = 1; i <= 511; i++) begin
         next_matrix = 1'b1;
         step();
         next_matrix = 1'b0;
         chk("step_valid_low", {199'd0, window_valid}, 200'd0);
         step();
         chk("step_valid_high", {199'd0, window_valid}, 200'd1);
         if (i == 1 || i == 255 || i == 510 || i == 511)
            chk("step_window", window_out, exp_win(5, 2, i, 0));
      end
      chk("w511_col4_zero", {192'd0, window_out[8*4 +: 8]}, 200'd0);
      chk("w511_col2_pix511", {192'd0, window_out[8*2 +: 8]}, 200'hFF);

      // Wrap back to column 0
      next_matrix = 1'b1;
      step();
      next_matrix = 1'b0;
      step();
      chk("wrap_valid", {199'd0, window_valid}, 200'd1);
      chk("wrap_window", window_out, exp_win(5, 2, 0, 0));

      // Word write and column step in the same cycle
      load_valid = 1'b1; h_count = 9'd0; v_count = 9'd5;
      step();
      load_valid = 1'b0; word_in = 32'hA3A2A1A0; next_matrix = 1'b1;
      step();
      next_matrix = 1'b0;
      chk("same_valid_t1", {199'd0, window_valid}, 200'd0);
      step();
      chk("same_valid_t2", {199'd0, window_valid}, 200'd1);
      ex = exp_win(5, 2, 1, 0);
      ex[8*1 +: 8] = 8'hA0; ex[8*2 +: 8] = 8'hA1;
      ex[8*3 +: 8] = 8'hA2; ex[8*4 +: 8] = 8'hA3;
      chk("same_window", window_out, ex);

      // Size change while READY
      size = 2'b01;
      step();
      chk("size_chg_valid_low", {199'd0, window_valid}, 200'd0);
      step();
      chk("size_chg_valid_high", {199'd0, window_valid}, 200'd1);
      chk("size_chg_window", window_out, exp_win(3, 1, 1, 2));

      // 2x2 on a restarted frame; third row evicts the first
      size = 2'b00;
      step();
      chk("k2_rows_ready_before", {199'd0, rows_ready}, 200'd1);
      load_row(0, 1'b1); step();
      chk("k2_rows_ready_after1", {199'd0, rows_ready}, 200'd0);
      load_row(1, 1'b0); step();
      chk("k2_rows_ready", {199'd0, rows_ready}, 200'd1);
      chk("k2_valid_t1", {199'd0, window_valid}, 200'd0);
      step();
      chk("k2_valid_t2", {199'd0, window_valid}, 200'd1);
      chk("k2_window", window_out, exp_win(2, 0, 0, 0));
      load_row(2, 1'b0); step(); step();
      chk("k2_evict_valid", {199'd0, window_valid}, 200'd1);
      chk("k2_evict_window", window_out, exp_win(2, 0, 0, 1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
